// File: rtl/cv32e40s_pkg.sv
// Shared types for the alert escalation path.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    ALERT_ESC_IDLE      = 2'd0,
    ALERT_ESC_COUNTING  = 2'd1,
    ALERT_ESC_ESCALATED = 2'd2,
    ALERT_ESC_LOCKED    = 2'd3
  } alert_esc_state_e;

endpackage

// File: rtl/cv32e40s_alert_leak_timer.sv
// Leak timer for the minor-alert bucket: counts 0..LEAK_PERIOD-1 while enabled.
// tick_o is combinational from the timer register; the timer wraps to 0 on tick, restart or disable.
module cv32e40s_alert_leak_timer #(
  parameter int LEAK_PERIOD = 1024,
  parameter int W           = $clog2(LEAK_PERIOD)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic tick_o
);

  localparam logic [W-1:0] LAST = W'(LEAK_PERIOD - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] timer_q;

  assign tick_o = enable && (timer_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (!enable || restart || tick_o) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + ONE;
    end
  end

endmodule

// File: rtl/cv32e40s_alert_escalator.sv
// Leaky-bucket accumulator of minor alerts with level-held escalation request
// and a sticky fatal lock on any major alert; all outputs registered.
module cv32e40s_alert_escalator
  import cv32e40s_pkg::*;
#(
  parameter int MINOR_THRESHOLD = 4,
  parameter int LEAK_PERIOD     = 1024,
  parameter int CNT_W           = $clog2(MINOR_THRESHOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alert_minor_i,
  input  logic             alert_major_i,
  input  logic             esc_ack_i,
  output logic             escalate_o,
  output logic             fatal_o,
  output logic [CNT_W-1:0] minor_cnt_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] S_IDLE      = ALERT_ESC_IDLE;
  localparam logic [1:0] S_COUNTING  = ALERT_ESC_COUNTING;
  localparam logic [1:0] S_ESCALATED = ALERT_ESC_ESCALATED;
  localparam logic [1:0] S_LOCKED    = ALERT_ESC_LOCKED;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(MINOR_THRESHOLD - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             leak_en, leak_tick;

  // Major alert freezes the timer in the same cycle it moves us to LOCKED.
  assign leak_en = (state_q == S_COUNTING) && !alert_major_i;

  cv32e40s_alert_leak_timer #(
    .LEAK_PERIOD (LEAK_PERIOD)
  ) u_leak_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (leak_en),
    .restart (alert_minor_i),
    .tick_o  (leak_tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (alert_major_i) begin
      state_d = S_LOCKED;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (alert_minor_i) begin
            cnt_d   = CNT_ONE;
            state_d = S_COUNTING;
          end
        end
        S_COUNTING: begin
          // A minor landing on a leak tick cancels out: count unchanged.
          if (alert_minor_i && !leak_tick) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_PRE) state_d = S_ESCALATED;
          end else if (!alert_minor_i && leak_tick) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = S_IDLE;
          end
        end
        S_ESCALATED: begin
          if (esc_ack_i) begin
            if (alert_minor_i) begin
              cnt_d   = CNT_ONE;
              state_d = S_COUNTING;
            end else begin
              cnt_d   = '0;
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      escalate_o <= 1'b0;
      fatal_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      escalate_o <= (state_d == S_ESCALATED);
      fatal_o    <= (state_d == S_LOCKED);
    end
  end

  assign minor_cnt_o = cnt_q;
  assign state_o     = state_q;

endmodule
